// File: rtl/sram_pkg.sv
// Shared SRAM port definitions: word/lane geometry and the byte-enable merge helper.
package sram_pkg;
  localparam int SRAM_DW = 32;
  localparam int SRAM_BE = 4;
  localparam int LANE_W  = 8;

  typedef logic [SRAM_DW-1:0] sram_word_t;
  typedef logic [SRAM_BE-1:0] sram_be_t;

  // New bytes where be=1, old bytes elsewhere.
  function automatic sram_word_t be_merge(input sram_word_t old_w,
                                          input sram_word_t new_w,
                                          input sram_be_t   be);
    sram_word_t m;
    m = old_w;
    for (int i = 0; i < SRAM_BE; i++) begin
      if (be[i]) m[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
    return m;
  endfunction
endpackage

// File: rtl/sram_byte_bank.sv
// One byte lane of the window: single-port RAM, registered read, write-first.
module sram_byte_bank #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  // Plain BRAM template: no reset on the array or the read register.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sram_responder.sv
// SRAM-like responder window: address decode, four byte banks, miss flag and saturating counters.
module sram_responder
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 12
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_sram_en,
  input  logic [SRAM_BE-1:0] i_sram_wen,
  input  logic [31:0]        i_sram_addr,
  input  logic [SRAM_DW-1:0] i_sram_wdata,
  output logic [SRAM_DW-1:0] o_sram_rdata,
  output logic               o_sram_err,
  output logic [31:0]        o_rd_cnt,
  output logic [31:0]        o_wr_cnt
);
  logic [31:0]        w_off;
  logic               w_hit;
  logic [AW-1:0]      w_idx;
  logic               w_bank_en;
  logic [SRAM_DW-1:0] w_bank_rdata;
  logic               w_unused;

  logic               r_sel;
  logic               r_err;
  logic [31:0]        r_rd_cnt;
  logic [31:0]        r_wr_cnt;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the window test.
  assign w_off     = i_sram_addr - BASE_ADDR;
  assign w_hit     = (w_off[31:AW+2] == {(30-AW){1'b0}});
  assign w_idx     = w_off[AW+1:2];
  assign w_bank_en = i_resetn & i_sram_en & w_hit;
  assign w_unused  = ^w_off[1:0];

  for (genvar g = 0; g < SRAM_BE; g++) begin : g_lane
    sram_byte_bank #(.AW(AW)) u_bank (
      .i_clk   (i_clk),
      .i_en    (w_bank_en),
      .i_we    (i_sram_wen[g]),
      .i_addr  (w_idx),
      .i_wdata (i_sram_wdata[g*LANE_W +: LANE_W]),
      .o_rdata (w_bank_rdata[g*LANE_W +: LANE_W])
    );
  end

  // r_sel gates bank data: cleared by reset/miss, so rdata reads 0 until the next hit.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sel    <= 1'b0;
      r_err    <= 1'b0;
      r_rd_cnt <= 32'h0;
      r_wr_cnt <= 32'h0;
    end else begin
      r_err <= i_sram_en & ~w_hit;
      if (i_sram_en) begin
        if (w_hit) begin
          r_sel <= 1'b1;
          if (|i_sram_wen) begin
            if (r_wr_cnt != 32'hFFFF_FFFF) r_wr_cnt <= r_wr_cnt + 32'd1;
          end else begin
            if (r_rd_cnt != 32'hFFFF_FFFF) r_rd_cnt <= r_rd_cnt + 32'd1;
          end
        end else begin
          r_sel <= 1'b0;
        end
      end
    end
  end

  assign o_sram_rdata = r_sel ? w_bank_rdata : 32'h0;
  assign o_sram_err   = r_err;
  assign o_rd_cnt     = r_rd_cnt;
  assign o_wr_cnt     = r_wr_cnt;
endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder against a word-array reference model.
module tb_sram_responder;
  import sram_pkg::*;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          AW    = 6;
  localparam int          DEPTH = 1 << AW;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  sram_responder #(.BASE_ADDR(BASE), .AW(AW)) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_sram_en    (en),
    .i_sram_wen   (wen),
    .i_sram_addr  (addr),
    .i_sram_wdata (wdata),
    .o_sram_rdata (rdata),
    .o_sram_err   (err),
    .o_rd_cnt     (rd_cnt),
    .o_wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
    logic [31:0] rd;
    logic [31:0] wr;
    logic        has_k;
    logic [31:0] k;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: words of the window plus which bytes are known.
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];
  logic [31:0] m_rdata, m_mask, m_rd, m_wr;
  logic        m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] known_mask(input logic [3:0] kn);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{kn[b]}};
    return m;
  endfunction

  task automatic model(input logic rst_n, input logic e, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] d);
    longint unsigned la, lb;
    int idx;
    la = {32'h0, a};
    lb = {32'h0, BASE};
    if (!rst_n) begin
      m_rdata = 32'h0; m_mask = 32'hFFFF_FFFF; m_err = 1'b0; m_rd = 32'h0; m_wr = 32'h0;
    end else if (!e) begin
      m_err = 1'b0;
    end else if (la < lb || (la - lb) >= longint'(DEPTH) * 4) begin
      m_rdata = 32'h0; m_mask = 32'hFFFF_FFFF; m_err = 1'b1;
    end else begin
      idx   = int'((la - lb) / 4);
      m_err = 1'b0;
      if (we == 4'h0) begin
        if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 32'd1;
      end else begin
        m_mem[idx]   = be_merge(m_mem[idx], d, we);
        m_known[idx] = m_known[idx] | we;
        if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 32'd1;
      end
      m_rdata = m_mem[idx];
      m_mask  = known_mask(m_known[idx]);
    end
  endtask

  task automatic push(input logic has_k, input logic [31:0] k);
    exp_t e;
    e.rdata = m_rdata; e.mask = m_mask; e.err = m_err;
    e.rd = m_rd; e.wr = m_wr; e.has_k = has_k; e.k = k;
    sb_q.push_back(e);
  endtask

  // One request per clock; the expectation for the following edge is queued.
  task automatic step(input logic rst_n, input logic e, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic has_k = 1'b0, input logic [31:0] k = 32'h0);
    @(posedge clk);
    #2;
    resetn = rst_n; en = e; wen = we; addr = a; wdata = d;
    model(rst_n, e, we, a, d);
    push(has_k, k);
  endtask

  // Preload the read counter near saturation during an idle cycle.
  task automatic force_rd(input logic [31:0] v);
    @(posedge clk);
    #2;
    force dut.r_rd_cnt = v;
    #1;
    release dut.r_rd_cnt;
    m_rd = v;
    resetn = 1'b1; en = 1'b0;
    model(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    push(1'b0, 32'h0);
  endtask

  // Monitor: compares DUT outputs 1 ns after each edge with the queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rdata", rdata & e.mask, e.rdata & e.mask);
      chk("err", {31'h0, err}, {31'h0, e.err});
      chk("rd_cnt", rd_cnt, e.rd);
      chk("wr_cnt", wr_cnt, e.wr);
      if (e.has_k) chk("rdata_const", rdata, e.k);
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    int sel;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'h0; m_known[i] = 4'h0;
    end
    m_rdata = 32'h0; m_mask = 32'h0; m_err = 1'b0; m_rd = 32'h0; m_wr = 32'h0;
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset and dropped write under reset
    step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
    step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
    step(1'b1, 1'b1, 4'hF, BASE, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D);
    repeat (3) step(1'b0, 1'b1, 4'hF, BASE, 32'hA5A5_5A5A, 1'b1, 32'h0);
    step(1'b1, 1'b1, 4'h0, BASE, 32'h0, 1'b1, 32'h0BAD_F00D);

    // Write/read and byte mask
    step(1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'h0, BASE + 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344, 1'b1, 32'hDE22_BE44);
    step(1'b1, 1'b1, 4'h0, BASE + 32'h12, 32'h0, 1'b1, 32'hDE22_BE44);

    // Back-to-back writes then reads
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'hF, BASE + 32'h20 + 32'(i*4), 32'hC0DE_0000 + 32'(i), 1'b1, 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'h0, BASE + 32'h20 + 32'(i*4), 32'h0, 1'b1, 32'hC0DE_0000 + 32'(i));

    // Misses above and below the window, including an aliasing write
    step(1'b1, 1'b1, 4'h0, BASE + 32'(DEPTH*4), 32'h0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 4'h0, BASE - 32'd4, 32'h0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 4'hF, BASE + 32'(DEPTH*4) + 32'h10, 32'h5555_AAAA, 1'b1, 32'h0);
    step(1'b1, 1'b1, 4'h0, BASE + 32'h10, 32'h0, 1'b1, 32'hDE22_BE44);

    // Idle hold with junk on wen/addr
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 4'($urandom), $urandom, $urandom, 1'b1, 32'hDE22_BE44);

    // Read counter saturation
    force_rd(32'hFFFF_FFFE);
    repeat (3) step(1'b1, 1'b1, 4'h0, BASE + 32'h20, 32'h0, 1'b1, 32'hC0DE_0000);
    step(1'b1, 1'b1, 4'h0, BASE - 32'd4, 32'h0, 1'b1, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 17)      a = BASE + ($urandom_range(0, DEPTH-1) << 2) + $urandom_range(0, 3);
      else if (sel == 17) a = BASE + 32'(DEPTH*4) + ($urandom_range(0, 255) << 2);
      else if (sel == 18) a = BASE - (($urandom_range(0, 15) + 32'd1) << 2);
      else                a = $urandom;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      d = $urandom;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), w, a, d);
    end

    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
